kamus_if_fetch: RTL and testbench



---
 rtl/kamus_pkg.sv | 24 ++
 rtl/kamus_fetch_fifo.sv | 56 +++++
 rtl/kamus_if_fetch.sv | 117 +++++++++++
 tb/tb_kamus_if_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// Shared kamus core types: fetch-queue entry layout, fetch granularity and the ID redirect-source select.
package kamus_pkg;

    localparam int unsigned KAMUS_XLEN        = 32;
    localparam int unsigned FETCH_WIDTH_BYTES = 4;

    typedef enum logic [1:0] {
        INSTR_ADDR_SEL_BOOT   = 2'd0,
        INSTR_ADDR_SEL_JUMP   = 2'd1,
        INSTR_ADDR_SEL_BRANCH = 2'd2,
        INSTR_ADDR_SEL_EXC    = 2'd3
    } instr_addr_sel_state_e;

    typedef struct packed {
        logic [KAMUS_XLEN-1:0] addr;
        logic [KAMUS_XLEN-1:0] data;
        logic                  err;
    } fq_entry_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/kamus_fetch_fifo.sv
// Synchronous FIFO of fq_entry_t with flush, occupancy output and same-cycle push+pop.
// A flush empties the queue; a push in the flush cycle becomes the sole surviving entry.
module kamus_fetch_fifo
    import kamus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fq_entry_t              wdata_i,
    input  logic                   pop_i,
    output fq_entry_t              rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, do_push, do_pop;

    always_comb begin
        full    = (count_q == (PTR_W+1)'(DEPTH));
        do_pop  = pop_i & (count_q != '0) & ~flush_i;
        do_push = push_i & (~full | do_pop | flush_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= do_push ? PTR_W'(1) : '0;
            count_q  <= do_push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read unless count_q says it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[flush_i ? '0 : wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/kamus_if_fetch.sv
// kamus instruction-fetch stage: L1I req/gnt/rvalid port, in-order fetch queue to ID, redirect flush.
// Build option KAMUS_IF_MISALIGN_EXC_EN: misaligned redirect yields one err=1 entry and halts fetch.
module kamus_if_fetch
    import kamus_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0,
    parameter int unsigned     FQ_DEPTH  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_data_o,
    output logic [XLEN-1:0] instr_addr_o,
    output logic            instr_err_o
);
    // Handshakes: a transfer happens at a posedge where valid (imem_req_o / instr_valid_o)
    // and ready (imem_gnt_i / instr_ready_i) are both high; payload is held stable until then,
    // and only a redirect may withdraw imem_req_o. rvalid responses are unconditionally accepted.
    localparam int unsigned     CNT_W   = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(FETCH_WIDTH_BYTES);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, pc_resp_q, pc_resp_d, target;
    logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d, occupancy;
    logic [CNT_W:0]   credit_used;
    logic             req, grant, resp, resp_keep, push, pop, misalign;
    logic             halt_q, halt_d, fifo_empty;
    fq_entry_t        push_entry, head;

`ifdef KAMUS_IF_MISALIGN_EXC_EN
    assign misalign = is_misaligned(redirect_addr_i[1:0]);
    assign target   = redirect_addr_i;
`else
    assign misalign = 1'b0;
    assign target   = redirect_addr_i & ~XLEN'(3);
`endif

    always_comb begin
        credit_used   = {1'b0, occupancy} + {1'b0, outstanding_q};
        req           = rst_ni & ~redirect_valid_i & ~halt_q & (credit_used < CREDITS);
        grant         = req & imem_gnt_i;
        // Responses with nothing outstanding belong to requests lost across a reset.
        resp          = imem_rvalid_i & (outstanding_q != '0);
        resp_keep     = resp & (discard_q == '0) & ~redirect_valid_i;
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp);
        pop           = instr_valid_o & instr_ready_i;
        push          = resp_keep;
        push_entry    = '{addr: pc_resp_q, data: imem_rdata_i, err: imem_err_i};
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        pc_resp_d     = pc_resp_q;
        halt_d        = halt_q;
        if (redirect_valid_i) begin
            // imem_req_o is low this cycle, so outstanding_d already excludes any new grant.
            discard_d  = outstanding_d;
            fetch_pc_d = target;
            pc_resp_d  = target;
            halt_d     = misalign;
            if (misalign) begin
                push       = 1'b1;
                push_entry = '{addr: target, data: '0, err: 1'b1};
            end
        end else begin
            if (resp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
            if (grant)     fetch_pc_d = fetch_pc_q + PC_STEP;
            if (resp_keep) pc_resp_d  = pc_resp_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q    <= BOOT_ADDR;
            pc_resp_q     <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            halt_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pc_resp_q     <= pc_resp_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halt_q        <= halt_d;
        end
    end

    kamus_fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = req ? fetch_pc_q : '0;
    assign instr_valid_o = ~fifo_empty;
    assign instr_addr_o  = instr_valid_o ? head.addr : '0;
    assign instr_data_o  = instr_valid_o ? head.data : '0;
    assign instr_err_o   = instr_valid_o & head.err;

endmodule

// File: tb/tb_kamus_if_fetch.sv
// Directed bench for kamus_if_fetch: L1I responder, grant-address model and entry scoreboard.
module tb_kamus_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_err;

    kamus_if_fetch dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .imem_err_i       (imem_err),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_data_o     (instr_data),
        .instr_addr_o     (instr_addr),
        .instr_err_o      (instr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops, n_err_pops;
    logic [64:0] exp_q[$];        // {addr, data, err}
    logic [32:0] pend_q[$];       // {stale, addr} granted, not yet answered
    logic [31:0] grant_log[$];
    logic [31:0] exp_fetch, err_addr;
    logic        resp_en;
    logic        cur_valid, cur_stale;
    logic [31:0] cur_addr;
    logic        last_req, last_valid, head_err;
    logic [31:0] last_addr, head_addr, head_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] grant_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF;
    endfunction

    // driver: one clock cycle; sample at negedge, drive #1 after posedge
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        logic [64:0] e;
        logic [32:0] p;
        @(negedge clk);
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_valid = instr_valid;
        head_addr  = instr_addr;
        head_data  = instr_data;
        head_err   = instr_err;
        g  = imem_req & imem_gnt;
        ga = imem_addr;
        if (g) begin
            check_eq("gnt_addr", ga, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            grant_log.push_back(ga);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            n_pops++;
            if (instr_err) n_err_pops++;
            check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("head_addr", instr_addr, e[64:33]);
                check_eq("head_data", instr_data, e[32:1]);
                check_eq("head_err", instr_err, e[0]);
            end
        end
        if (redirect_valid) begin
            check_eq("req_in_redirect", imem_req, 0);
            exp_q.delete();
            for (int i = 0; i < pend_q.size(); i++) pend_q[i][32] = 1'b1;
`ifdef KAMUS_IF_MISALIGN_EXC_EN
            exp_fetch = redirect_addr;
            if (redirect_addr[1:0] != 2'b00) exp_q.push_back({redirect_addr, 32'h0, 1'b1});
`else
            exp_fetch = {redirect_addr[31:2], 2'b00};
`endif
        end else if (cur_valid && !cur_stale) begin
            exp_q.push_back({cur_addr, mem_word(cur_addr), cur_addr == err_addr});
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (g) pend_q.push_back({1'b0, ga});
        cur_valid   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_err    = 1'b0;
        if (resp_en && pend_q.size() != 0) begin
            p           = pend_q.pop_front();
            cur_valid   = 1'b1;
            cur_stale   = p[32];
            cur_addr    = p[31:0];
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(cur_addr);
            imem_err    = (cur_addr == err_addr);
        end
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
    endtask

    task automatic drain();
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        resp_en     = 1'b1;
        repeat (6) tick();
    endtask

    task automatic wait_head(output logic found);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            found = last_valid;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        logic        found;
        logic [31:0] base;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
        instr_ready = 1'b0; resp_en = 1'b0;
        cur_valid = 1'b0; cur_stale = 1'b0; cur_addr = '0;
        exp_fetch = 32'h0; err_addr = 32'hFFFF_FFFF;
        n_pops = 0; n_err_pops = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_iaddr", instr_addr, 0);
        check_eq("rst_idata", instr_data, 0);
        check_eq("rst_ierr", instr_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1; resp_en = 1'b1;

        // streaming from BOOT_ADDR: latency 3, then one per cycle
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (last_valid && first == 0) first = c;
        end
        check_eq("first_valid_cycle", first, 3);
        n_pops = 0;
        repeat (8) tick();
        check_eq("throughput", n_pops, 8);

        // ID stall fills the queue through credits only
        drain();
        base = exp_fetch;
        grant_log.delete();
        instr_ready = 1'b0; imem_gnt = 1'b1;
        repeat (8) tick();
        check_eq("grants_stalled", grant_log.size(), 4);
        check_eq("req_full", last_req, 0);
        check_eq("valid_full", last_valid, 1);
        check_eq("head_full", head_addr, base);
        instr_ready = 1'b1;
        grant_log.delete();
        repeat (4) tick();
        check_eq("resume_addr", grant_at(0), base + 32'd16);

        // two in flight (8, 12) dropped by a redirect to 0x100
        drain();
        redirect_to(32'h8); tick();
        resp_en = 1'b0; imem_gnt = 1'b1;
        grant_log.delete();
        repeat (2) tick();
        check_eq("inflight_0", grant_at(0), 32'h8);
        check_eq("inflight_1", grant_at(1), 32'hC);
        imem_gnt = 1'b0;
        redirect_to(32'h100); resp_en = 1'b1; imem_gnt = 1'b1;
        wait_head(found);
        check_eq("t3_seen", found, 1);
        check_eq("t3_addr", head_addr, 32'h100);
        check_eq("t3_data", head_data, mem_word(32'h100));

        // redirect coinciding with rvalid and gnt
        drain();
        redirect_to(32'h40); tick();
        resp_en = 1'b0; imem_gnt = 1'b1;
        repeat (2) tick();
        imem_gnt = 1'b0; resp_en = 1'b1;
        tick();
        check_eq("t4_rvalid_set", imem_rvalid, 1);
        redirect_to(32'h200); imem_gnt = 1'b1;
        tick();
        check_eq("t4_req_N", last_req, 0);
        tick();
        check_eq("t4_req_N1", last_req, 1);
        check_eq("t4_addr_N1", last_addr, 32'h200);
        wait_head(found);
        check_eq("t4_seen", found, 1);
        check_eq("t4_addr", head_addr, 32'h200);
        check_eq("t4_data", head_data, mem_word(32'h200));

        // bus error on 0x10 marks exactly that entry
        drain();
        err_addr = 32'h10;
        redirect_to(32'h8); imem_gnt = 1'b1;
        n_err_pops = 0;
        repeat (10) tick();
        check_eq("t5_err_pops", n_err_pops, 1);
        drain();
        err_addr = 32'hFFFF_FFFF;

        // fetch address wraps modulo 2^32
        redirect_to(32'hFFFF_FFF8); tick();
        grant_log.delete();
        imem_gnt = 1'b1;
        repeat (6) tick();
        check_eq("wrap_0", grant_at(0), 32'hFFFF_FFF8);
        check_eq("wrap_1", grant_at(1), 32'hFFFF_FFFC);
        check_eq("wrap_2", grant_at(2), 32'h0);
        check_eq("wrap_3", grant_at(3), 32'h4);

        // misaligned redirect target
        drain();
        grant_log.delete();
        redirect_to(32'h102); imem_gnt = 1'b1;
        wait_head(found);
        check_eq("mis_seen", found, 1);
`ifdef KAMUS_IF_MISALIGN_EXC_EN
        check_eq("mis_addr", head_addr, 32'h102);
        check_eq("mis_err", head_err, 1);
        check_eq("mis_data", head_data, 0);
        repeat (4) tick();
        check_eq("mis_no_grants", grant_log.size(), 0);
`else
        check_eq("mis_addr", head_addr, 32'h100);
        check_eq("mis_err", head_err, 0);
        check_eq("mis_first_gnt", grant_at(0), 32'h100);
`endif

        drain();
        check_eq("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
